jk_excitation_driver: RTL
=========================

Name: jk_excitation_driver

Overview:
Drives an external JK flip-flop so that its output follows a stream of target bits. Target bits arrive on a valid/ready input and are buffered in a small FIFO. For each bit the block reads the flip-flop's current state, derives the J/K excitation from the inverse of the JK characteristic table, and checks the flip-flop's next state and complement output. Its job is closed-loop stimulus and self-check for jk_flipflop instances in the team's benches and in on-chip BIST.

Parameters:
DEPTH, 4, target FIFO depth in entries; must be a power of two and at least 2
CNT_W, 8, width of the pass and error counters
USE_TOGGLE, 0, 1 = state changes use J=K=1; 0 = state changes use set (J=1,K=0) or reset (J=0,K=1)

Ports:
clk  in  1  clock; all logic is on the rising edge
rst  in  1  synchronous, active-high reset
tgt_valid  in  1  target bit offered
tgt_data  in  1  desired next flip-flop state
tgt_ready  out  1  FIFO can accept a bit
j  out  1  J input to the flip-flop under test (registered)
k  out  1  K input to the flip-flop under test (registered)
q_fb  in  1  flip-flop q output
q1_fb  in  1  flip-flop complement output
busy  out  1  FIFO not empty or FSM not IDLE
mismatch  out  1  one-cycle pulse on a failed check
pass_count  out  CNT_W  checks passed
err_count  out  CNT_W  checks failed

Behaviour:
- Reset (rst=1 sampled at a clk edge):
  - j=0, k=0, mismatch=0, pass_count=0, err_count=0.
  - FIFO emptied; FSM goes to IDLE; tgt_ready=1 on the cycle after reset.
  - A reset mid-operation discards the current bit and all queued bits; nothing is counted for them.
- FIFO:
  - Accept when tgt_valid & tgt_ready.
  - tgt_ready = not full.
  - A push and a pop in the same cycle are both honoured; occupancy is unchanged.
  - Read and write pointers wrap modulo DEPTH.
  - A push while full is impossible because tgt_ready=0.
- FSM states: IDLE, DRIVE, SETTLE, CHECK.
  - IDLE: j=k=0. If the FIFO is non-empty, pop the head into tgt_r, sample q_fb into q_r, and go to DRIVE.
  - DRIVE: register j/k from (q_r, tgt_r):
    - q_r=0, tgt_r=0: J=0, K=0.
    - q_r=1, tgt_r=1: J=0, K=0.
    - q_r=0, tgt_r=1: J=1, K=0 (J=1, K=1 if USE_TOGGLE).
    - q_r=1, tgt_r=0: J=0, K=1 (J=1, K=1 if USE_TOGGLE).
    - Go to SETTLE.
  - SETTLE: j/k held for one full cycle so the flip-flop captures them on this cycle's closing edge. Go to CHECK.
  - CHECK: j,k forced to 0.
    - Pass when q_fb==tgt_r and q1_fb==~q_fb; pass_count is incremented.
    - Otherwise err_count is incremented and mismatch pulses for one cycle.
    - Next state: if the FIFO is non-empty, pop the next bit and sample q_fb (the just-checked state) into q_r, then go to DRIVE. If the FIFO is empty, go to IDLE.
- Latency:
  - First bit into an empty, IDLE block: accepted at edge E0; pop at E1; j/k valid after E2; the flip-flop updates at E3; result (count/mismatch) visible after E4.
  - Back-to-back throughput: one bit per 3 cycles.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Excitation is always derived from the sampled q_fb, never from tgt history. A flip-flop that fails once does not cascade errors onto later bits.
- busy = (FSM != IDLE) | FIFO non-empty.

Test Plan:
- Reset, then push bits 1,1,0,0,1 with q starting at 0 and USE_TOGGLE=0:
  - j/k sequence is (1,0), (0,0), (0,1), (0,0), (1,0).
  - pass_count=5, err_count=0, mismatch never asserted.
- USE_TOGGLE=1, push 1,0,1:
  - j/k is (1,1) for every bit.
  - pass_count=3.
- Fill the FIFO with DEPTH bits while the FSM is stalled in the first bit:
  - tgt_ready=0 after DEPTH+1 accepts (one in the FSM, DEPTH queued).
  - tgt_ready returns to 1 the cycle after the next pop.
  - Pointer wrap is exercised over 3*DEPTH bits with no loss or reorder.
- Bench forces q_fb stuck at 0, push 1 then 0:
  - First check fails: mismatch pulse, err_count=1.
  - Second bit gets excitation (0,0) (q_r=0, tgt_r=0) and passes.
  - Final counts: pass_count=1, err_count=1.
- Bench forces q1_fb=q_fb with a correct q:
  - Every check fails; err_count equals the number of bits pushed.
- CNT_W=2, push 5 passing bits:
  - pass_count saturates at 3.
- Assert rst during SETTLE with 2 bits queued:
  - Next cycle: j=k=0, FIFO empty, busy=0.
  - Counters are 0; no mismatch pulse.

Source files
------------

// File: rtl/jk_excitation_driver_if.sv
// Target-bit stream into the JK excitation driver: one desired flip-flop state
// per valid/ready transfer.
interface jk_excitation_driver_if;
  logic tgt_valid;
  logic tgt_data;
  logic tgt_ready;

  modport master (
    output tgt_valid,
    output tgt_data,
    input  tgt_ready
  );

  modport slave (
    input  tgt_valid,
    input  tgt_data,
    output tgt_ready
  );
endinterface

// File: rtl/jk_excitation_driver.sv
// Closed-loop JK excitation driver: buffers target bits, drives an external JK
// flip-flop toward each one, then checks the resulting q / q1 pair.
module jk_excitation_driver #(
  parameter int DEPTH      = 4,
  parameter int CNT_W      = 8,
  parameter int USE_TOGGLE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  jk_excitation_driver_if.slave tgt,
  output logic                  j,
  output logic                  k,
  input  logic                  q_fb,
  input  logic                  q1_fb,
  output logic                  busy,
  output logic                  mismatch,
  output logic [CNT_W-1:0]      pass_count,
  output logic [CNT_W-1:0]      err_count
);

  localparam int          AW     = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ZERO_C = {(AW+1){1'b0}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } state_t;

  // Inverse JK characteristic table: {J,K} that moves q to t on the next edge.
  function automatic logic [1:0] excite(input logic q, input logic t);
    logic [1:0] jk;
    if (q == t) begin
      jk = 2'b00;
    end else if (USE_TOGGLE != 0) begin
      jk = 2'b11;
    end else if (t) begin
      jk = 2'b10;
    end else begin
      jk = 2'b01;
    end
    return jk;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (&v) begin
      r = v;
    end else begin
      r = v + 1'b1;
    end
    return r;
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic             mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic [AW:0]      count_nxt_s;
  logic             ready_r;
  logic             busy_r;
  logic             tgt_r;
  logic             q_r;
  logic             j_r;
  logic             k_r;
  logic             mismatch_r;
  logic [CNT_W-1:0] pass_r;
  logic [CNT_W-1:0] err_r;
  logic             push_s;
  logic             pop_s;
  logic             nonempty_s;
  logic [1:0]       jk_nxt_s;
  logic             chk_pass_s;
  logic             chk_fail_s;

  assign push_s     = tgt.tgt_valid & ready_r;
  assign nonempty_s = (count_r != ZERO_C);

  assign tgt.tgt_ready = ready_r;
  assign j             = j_r;
  assign k             = k_r;
  assign busy          = busy_r;
  assign mismatch      = mismatch_r;
  assign pass_count    = pass_r;
  assign err_count     = err_r;

  // FSM next state, pop request, excitation and check verdict.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    jk_nxt_s    = 2'b00;
    chk_pass_s  = 1'b0;
    chk_fail_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (nonempty_s) begin
          pop_s       = 1'b1;
          state_nxt_s = DRIVE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DRIVE: begin
        jk_nxt_s    = excite(q_r, tgt_r);
        state_nxt_s = SETTLE;
      end
      SETTLE: begin
        // j/k registered in DRIVE are on the pins for this whole cycle; clear them for CHECK.
        state_nxt_s = CHECK;
      end
      CHECK: begin
        if ((q_fb == tgt_r) && (q1_fb == ~q_fb)) begin
          chk_pass_s = 1'b1;
        end else begin
          chk_fail_s = 1'b1;
        end
        if (nonempty_s) begin
          pop_s       = 1'b1;
          state_nxt_s = DRIVE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FIFO occupancy after this cycle's push and pop.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + 1'b1;
      2'b01:   count_nxt_s = count_r - 1'b1;
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= tgt.tgt_data;
    end
  end

  // Pointers, FSM state, registered pins and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= ZERO_C;
      ready_r    <= 1'b1;
      busy_r     <= 1'b0;
      tgt_r      <= 1'b0;
      q_r        <= 1'b0;
      j_r        <= 1'b0;
      k_r        <= 1'b0;
      mismatch_r <= 1'b0;
      pass_r     <= {CNT_W{1'b0}};
      err_r      <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      count_r    <= count_nxt_s;
      ready_r    <= (count_nxt_s != FULL_C);
      busy_r     <= (state_nxt_s != IDLE) || (count_nxt_s != ZERO_C);
      j_r        <= jk_nxt_s[1];
      k_r        <= jk_nxt_s[0];
      mismatch_r <= chk_fail_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
        tgt_r    <= mem_r[rd_ptr_r];
        q_r      <= q_fb;
      end
      if (chk_pass_s) begin
        pass_r <= sat_inc(pass_r);
      end
      if (chk_fail_s) begin
        err_r <= sat_inc(err_r);
      end
    end
  end

endmodule
